// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key_debounce slice: per-channel FSM encoding and
// the stable-counter width.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM with stable counter and,
// when KEY_REPEAT_EN is defined, an auto-repeat counter active while PRESSED.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEB_TICKS     = 8,
  parameter int unsigned ACTIVE_LOW    = 0
`ifdef KEY_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = 384,
  parameter int unsigned REPEAT_PERIOD = 76
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  logic [1:0]       sync_q, sync_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             s;

  assign sync_d = {sync_q[0], key_raw};
  assign s      = (ACTIVE_LOW != 0) ? ~sync_q[1] : sync_q[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    cnt_inc   = cnt_q + CNT_W'(1);
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (s) begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_W'(DEB_TICKS)) begin
            state_d = PRESSED;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        PRESSED: begin
          if (!s) begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_W'(DEB_TICKS)) begin
            state_d   = IDLE;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_level   = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
  assign key_press   = press_q;
  assign key_release = release_q;

`ifdef KEY_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_DELAY + 1);

  logic [REP_W-1:0] rep_q, rep_d, rep_inc;
  logic             repeat_q, repeat_d;

  // Reloading to DELAY-PERIOD makes every later pulse land PERIOD ticks apart.
  always_comb begin
    rep_d    = rep_q;
    repeat_d = 1'b0;
    rep_inc  = rep_q + REP_W'(1);
    if (tick) begin
      if ((state_d == PRESSED) && (state_q != PRESSED)) begin
        rep_d = '0;
      end else if (state_q == PRESSED) begin
        if (rep_inc == REP_W'(REPEAT_DELAY)) begin
          repeat_d = 1'b1;
          rep_d    = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);
        end else begin
          rep_d = rep_inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q    <= '0;
      repeat_q <= 1'b0;
    end else begin
      rep_q    <= rep_d;
      repeat_q <= repeat_d;
    end
  end

  assign key_repeat = repeat_q;
`else
  assign key_repeat = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: sample strobe from div_res[TICK_BIT] rising edge shared
// by N_KEYS channels. Define KEY_REPEAT_EN to enable auto-repeat pulses.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned N_KEYS        = 5,
  parameter int unsigned TICK_BIT      = 16,
  parameter int unsigned DEB_TICKS     = 8,
  parameter int unsigned ACTIVE_LOW    = 0,
  parameter int unsigned REPEAT_DELAY  = 384,
  parameter int unsigned REPEAT_PERIOD = 76
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       div_res,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat
);

  if (DEB_TICKS < 2 || DEB_TICKS > 255) begin : g_bad_deb
    $error("key_debounce: DEB_TICKS must be in 2..255");
  end
  if (TICK_BIT > 31) begin : g_bad_tick
    $error("key_debounce: TICK_BIT must be in 0..31");
  end
  if (REPEAT_PERIOD == 0 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_rep
    $error("key_debounce: REPEAT_PERIOD must be in 1..REPEAT_DELAY");
  end

  logic prev_q, prev_d;
  logic tick_q, tick_d;
  logic unused_div;

  assign unused_div = ^div_res;

  always_comb begin
    prev_d = div_res[TICK_BIT];
    tick_d = div_res[TICK_BIT] & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      tick_q <= tick_d;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEB_TICKS     (DEB_TICKS),
      .ACTIVE_LOW    (ACTIVE_LOW)
`ifdef KEY_REPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick_q),
      .key_raw     (key_raw[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_repeat  (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with TICK_BIT=2, DEB_TICKS=4, N_KEYS=2;
// a second instance covers ACTIVE_LOW=1.
module tb_key_debounce;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] div_res;
  logic [1:0]  key_raw    = 2'b00;
  logic [1:0]  key_raw_al = 2'b11;
  logic [1:0]  lvl, prs, rel, rpt;
  logic [1:0]  al_lvl, al_prs, al_rel, al_rpt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pc[2], rc[2], rp[2], pcyc[2];
  int rcyc[4];
  int al_pc = 0, al_rc = 0, al_pcyc = 0, al_other = 0;
  int coinc = 0, rep_total = 0;
  int t0, lat;

  key_debounce #(
    .N_KEYS(2), .TICK_BIT(2), .DEB_TICKS(4), .ACTIVE_LOW(0),
    .REPEAT_DELAY(6), .REPEAT_PERIOD(2)
  ) dut (
    .clk(clk), .rst(rst), .div_res(div_res), .key_raw(key_raw),
    .key_level(lvl), .key_press(prs), .key_release(rel), .key_repeat(rpt)
  );

  key_debounce #(
    .N_KEYS(2), .TICK_BIT(2), .DEB_TICKS(4), .ACTIVE_LOW(1),
    .REPEAT_DELAY(6), .REPEAT_PERIOD(2)
  ) dut_al (
    .clk(clk), .rst(rst), .div_res(div_res), .key_raw(key_raw_al),
    .key_level(al_lvl), .key_press(al_prs), .key_release(al_rel), .key_repeat(al_rpt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) div_res <= '0;
    else     div_res <= div_res + 32'd1;
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (prs[i]) begin pc[i] = pc[i] + 1; pcyc[i] = cyc; end
      if (rel[i]) rc[i] = rc[i] + 1;
      if (rpt[i]) begin
        if (i == 1 && rp[1] < 4) rcyc[rp[1]] = cyc;
        rp[i] = rp[i] + 1;
        rep_total = rep_total + 1;
      end
      if (prs[i] && rel[i]) coinc = coinc + 1;
      if (rel[i] && rpt[i]) coinc = coinc + 1;
    end
    if (al_prs[0]) begin al_pc = al_pc + 1; al_pcyc = cyc; end
    if (al_rel[0]) al_rc = al_rc + 1;
    if (al_prs[1] || al_rel[1]) al_other = al_other + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      pc[i] = 0; rc[i] = 0; rp[i] = 0; pcyc[i] = 0;
    end
    for (int i = 0; i < 4; i++) rcyc[i] = 0;
    al_pc = 0; al_rc = 0; al_pcyc = 0; al_other = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_raw = 2'b00; key_raw_al = 2'b11;
    clear_counts();
    step(3);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({lvl, prs, rel, rpt} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: got %b expected 00000000", {lvl, prs, rel, rpt});
    end
    checks++;
    if ({al_lvl, al_prs, al_rel, al_rpt} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs_al: got %b expected 00000000", {al_lvl, al_prs, al_rel, al_rpt});
    end
    step(8);
  endtask

  task automatic test_clean_press();
    clear_counts();
    t0 = cyc; key_raw[0] = 1'b1;
    step(50);
    checks++;
    if (pc[0] !== 1) begin errors++; $display("FAIL clean_press_count: got %0d expected 1", pc[0]); end
    lat = pcyc[0] - t0;
    checks++;
    if (lat < 24 || lat > 36) begin errors++; $display("FAIL clean_press_latency: got %0d expected 24..36", lat); end
    checks++;
    if (lvl[0] !== 1'b1) begin errors++; $display("FAIL clean_press_level: got %b expected 1", lvl[0]); end
    checks++;
    if (pc[1] !== 0 || lvl[1] !== 1'b0) begin
      errors++; $display("FAIL clean_press_ch1_quiet: got press=%0d level=%b expected 0 0", pc[1], lvl[1]);
    end
    checks++;
    if (al_pc !== 0) begin errors++; $display("FAIL clean_press_al_quiet: got %0d expected 0", al_pc); end
  endtask

  task automatic test_clean_release();
    clear_counts();
    key_raw[0] = 1'b0;
    step(50);
    checks++;
    if (rc[0] !== 1) begin errors++; $display("FAIL clean_release_count: got %0d expected 1", rc[0]); end
    checks++;
    if (lvl[0] !== 1'b0) begin errors++; $display("FAIL clean_release_level: got %b expected 0", lvl[0]); end
    checks++;
    if (pc[0] !== 0) begin errors++; $display("FAIL clean_release_no_press: got %0d expected 0", pc[0]); end
  endtask

  task automatic test_bouncy_press();
    clear_counts();
    for (int k = 0; k < 6; k++) begin
      key_raw[0] = (k % 2 == 0);
      step(10);
    end
    checks++;
    if (pc[0] !== 0 || lvl[0] !== 1'b0) begin
      errors++; $display("FAIL bouncy_no_early_press: got press=%0d level=%b expected 0 0", pc[0], lvl[0]);
    end
    t0 = cyc; key_raw[0] = 1'b1;
    step(50);
    checks++;
    if (pc[0] !== 1) begin errors++; $display("FAIL bouncy_press_count: got %0d expected 1", pc[0]); end
    lat = pcyc[0] - t0;
    checks++;
    if (lat < 24 || lat > 36) begin errors++; $display("FAIL bouncy_press_latency: got %0d expected 24..36", lat); end
    key_raw[0] = 1'b0;
    step(50);
    checks++;
    if (rc[0] !== 1 || lvl[0] !== 1'b0) begin
      errors++; $display("FAIL bouncy_release: got count=%0d level=%b expected 1 0", rc[0], lvl[0]);
    end
  endtask

  task automatic test_release_glitch();
    key_raw[0] = 1'b1;
    step(50);
    clear_counts();
    key_raw[0] = 1'b0;
    step(16);
    checks++;
    if (lvl[0] !== 1'b1) begin errors++; $display("FAIL glitch_level_during: got %b expected 1", lvl[0]); end
    key_raw[0] = 1'b1;
    step(50);
    checks++;
    if (rc[0] !== 0 || pc[0] !== 0) begin
      errors++; $display("FAIL glitch_no_pulses: got release=%0d press=%0d expected 0 0", rc[0], pc[0]);
    end
    checks++;
    if (lvl[0] !== 1'b1) begin errors++; $display("FAIL glitch_level_after: got %b expected 1", lvl[0]); end
    key_raw[0] = 1'b0;
    step(50);
    checks++;
    if (rc[0] !== 1 || lvl[0] !== 1'b0) begin
      errors++; $display("FAIL glitch_final_release: got count=%0d level=%b expected 1 0", rc[0], lvl[0]);
    end
  endtask

  task automatic test_reset_mid();
    clear_counts();
    key_raw[0] = 1'b1;
    step(26);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({lvl, prs, rel, rpt} !== 8'h00) begin
      errors++; $display("FAIL reset_mid_outputs: got %b expected 00000000", {lvl, prs, rel, rpt});
    end
    checks++;
    if (pc[0] !== 0) begin errors++; $display("FAIL reset_mid_no_press: got %0d expected 0", pc[0]); end
    step(23);
    checks++;
    if (pc[0] !== 0) begin errors++; $display("FAIL reset_mid_requalify: got %0d expected 0", pc[0]); end
    step(20);
    checks++;
    if (pc[0] !== 1 || lvl[0] !== 1'b1) begin
      errors++; $display("FAIL reset_mid_fresh_press: got count=%0d level=%b expected 1 1", pc[0], lvl[0]);
    end
    key_raw[0] = 1'b0;
    step(50);
  endtask

  task automatic test_active_low();
    clear_counts();
    t0 = cyc; key_raw_al[0] = 1'b0;
    step(50);
    checks++;
    if (al_pc !== 1) begin errors++; $display("FAIL al_press_count: got %0d expected 1", al_pc); end
    lat = al_pcyc - t0;
    checks++;
    if (lat < 24 || lat > 36) begin errors++; $display("FAIL al_press_latency: got %0d expected 24..36", lat); end
    checks++;
    if (al_lvl !== 2'b01 || al_other !== 0) begin
      errors++; $display("FAIL al_level: got level=%b other=%0d expected 01 0", al_lvl, al_other);
    end
    key_raw_al[0] = 1'b1;
    step(50);
    checks++;
    if (al_rc !== 1 || al_lvl[0] !== 1'b0) begin
      errors++; $display("FAIL al_release: got count=%0d level=%b expected 1 0", al_rc, al_lvl[0]);
    end
  endtask

  task automatic test_repeat();
    clear_counts();
    key_raw[1] = 1'b1;
`ifdef KEY_REPEAT_EN
    step(40);
    checks++;
    if (pc[1] !== 1) begin errors++; $display("FAIL repeat_press: got %0d expected 1", pc[1]); end
    step(78);
    checks++;
    if (rp[1] !== 3) begin errors++; $display("FAIL repeat_count: got %0d expected 3", rp[1]); end
    checks++;
    if (rcyc[0] - pcyc[1] !== 48) begin errors++; $display("FAIL repeat_first: got %0d expected 48", rcyc[0] - pcyc[1]); end
    checks++;
    if (rcyc[1] - pcyc[1] !== 64) begin errors++; $display("FAIL repeat_second: got %0d expected 64", rcyc[1] - pcyc[1]); end
    checks++;
    if (rcyc[2] - pcyc[1] !== 80) begin errors++; $display("FAIL repeat_third: got %0d expected 80", rcyc[2] - pcyc[1]); end
`else
    step(150);
    checks++;
    if (pc[1] !== 1 || rp[1] !== 0) begin
      errors++; $display("FAIL repeat_disabled_hold: got press=%0d repeat=%0d expected 1 0", pc[1], rp[1]);
    end
`endif
    key_raw[1] = 1'b0;
    step(50);
    checks++;
    if (rc[1] !== 1 || lvl[1] !== 1'b0) begin
      errors++; $display("FAIL repeat_release: got count=%0d level=%b expected 1 0", rc[1], lvl[1]);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_clean_release();
    test_bouncy_press();
    test_release_glitch();
    test_reset_mid();
    test_active_low();
    test_repeat();
    checks++;
    if (coinc !== 0) begin errors++; $display("FAIL exclusive_pulses: got %0d expected 0", coinc); end
`ifndef KEY_REPEAT_EN
    checks++;
    if (rep_total !== 0) begin errors++; $display("FAIL repeat_tied_low: got %0d expected 0", rep_total); end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Multi-channel push-button conditioner placed directly downstream of the free-running clock divider. It takes the divider's 32-bit count, derives a slow sample strobe from one selected bit, and synchronises and debounces each raw board key. Per key it produces a clean level plus one-cycle press and release pulses for the game-control logic. Optional auto-repeat pulses support held keys.

## Interface
- `N_KEYS`, default 5: number of key channels.
- `TICK_BIT`, default 16: index of the `div_res` bit whose rising edge is the sample strobe. Gives a 2^17-cycle period, 1.31 ms at 100 MHz.
- `DEB_TICKS`, default 8: consecutive equal samples required to accept a level change. Range 2..255.
- `ACTIVE_LOW`, default 0: 1 means the raw key reads 0 when pressed.
- `REPEAT_DELAY`, default 384: ticks held in PRESSED before the first repeat pulse.
- `REPEAT_PERIOD`, default 76: ticks between later repeat pulses.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `div_res`, in, 32: divider count, same clock domain.
- `key_raw`, in, N_KEYS: asynchronous board keys.
- `key_level`, out, N_KEYS: debounced level; 1 means pressed.
- `key_press`, out, N_KEYS: one-cycle pulse on an accepted press.
- `key_release`, out, N_KEYS: one-cycle pulse on an accepted release.
- `key_repeat`, out, N_KEYS: one-cycle auto-repeat pulse.

## Operation
- **Strobe.** Register `div_res[TICK_BIT]` as `prev`. `tick = div_res[TICK_BIT] & ~prev`. `tick` is shared by all channels.
- **Synchroniser.** Each key passes through a 2-flop synchroniser. Polarity is normalised after the synchroniser, using `ACTIVE_LOW`, so that s=1 means pressed.
- **Per-channel FSM.** States are IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Each channel has a 8-bit stable counter `cnt`. All transitions happen only on cycles where `tick`=1.
  - IDLE: s=1 → PRESS_WAIT with cnt=1.
  - PRESS_WAIT: s=1 → cnt+1; when cnt+1==DEB_TICKS → PRESSED and assert `key_press`. s=0 → IDLE with cnt=0.
  - PRESSED: s=0 → RELEASE_WAIT with cnt=1.
  - RELEASE_WAIT: s=0 → cnt+1; when cnt+1==DEB_TICKS → IDLE and assert `key_release`. s=1 → PRESSED with cnt=0. A bounce during release produces no extra press pulse.
- **key_level.** `key_level`=1 in PRESSED and RELEASE_WAIT; 0 otherwise.
- **Channel independence.** Channels are fully independent. Simultaneous presses on several keys give simultaneous pulses.
- **Reset.** All state, counters, `prev` and outputs clear to 0; FSMs go to IDLE. A pending press or release is discarded and no pulse is emitted.

## Timing
- Pulse outputs are registered and last exactly one `clk` cycle. They are asserted in the cycle after the deciding `tick` cycle.
- `tick` is high for one cycle, one cycle after the selected bit rises.
- Press latency, from a stable raw edge to `key_press`: between (DEB_TICKS−1)·2^(TICK_BIT+1) and DEB_TICKS·2^(TICK_BIT+1) cycles, plus 4 cycles.
- When the divider resets together with this block, the first `tick` occurs 2^TICK_BIT+1 cycles after reset deasserts.
- For a given key, press and release pulses can never coincide. Release and repeat pulses are also mutually exclusive.

## Configuration
- `KEY_REPEAT_EN` defined:
  - Each channel has a repeat counter, width $clog2(REPEAT_DELAY+1).
  - The counter clears on entering PRESSED and counts ticks while the channel is in PRESSED.
  - At REPEAT_DELAY it pulses `key_repeat` and reloads to REPEAT_DELAY−REPEAT_PERIOD, so later pulses arrive every REPEAT_PERIOD ticks.
  - The counter holds its value in RELEASE_WAIT. It clears on return from RELEASE_WAIT to PRESSED.
- `KEY_REPEAT_EN` undefined: the repeat logic is absent and `key_repeat` is tied to 0. The port remains.

## Structure
- A shared package holds:
  - The FSM state encoding: IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3.
  - The counter width constant (8).
- Sub-module `key_debounce_ch`: one channel holding the synchroniser, FSM, stable counter and optional repeat counter.
- The top level holds the strobe edge detector and a generate loop over N_KEYS.

## Test plan
All scenarios use TICK_BIT=2 (tick every 8 cycles), DEB_TICKS=4, N_KEYS=2, with `div_res` driven by a counter reset alongside the block.
- **Clean press.** `key_raw[0]`=1 held → one `key_press[0]` pulse ~32 cycles later; `key_level[0]`=1; no pulse on channel 1.
- **Bouncy press.** Toggle `key_raw[0]` every 10 cycles for 60 cycles, then hold 1 → exactly one `key_press`, only after 4 stable ticks.
- **Release glitch.** Glitch to 0 for 2 ticks, then back to 1 → no `key_release`; `key_level` stays 1; a later stable release gives exactly one `key_release`.
- **Reset mid-operation.** Assert `rst` for 1 cycle at PRESS_WAIT cnt=3 → all outputs 0 next cycle; no press pulse; a fresh 4-tick qualification is needed.
- **ACTIVE_LOW=1.** Idle-high raw, drop to 0 → `key_press` as in the clean-press case; `key_raw` never inverted on output.
- **KEY_REPEAT_EN.** Defined with REPEAT_DELAY=6, REPEAT_PERIOD=2, hold key → repeat pulses 6, 8, 10 ticks after entering PRESSED. Undefined → `key_repeat` constantly 0.
